// File: rtl/gshare_pht.sv
// gshare_pht: gshare-indexed pattern history table of CTR_WIDTH-bit saturating
// counters with speculative global history, mispredict snapshot restore and a
// sequential post-reset table initialisation.
// Optional macro PHT_FWD_EN: forward a same-cycle update to the lookup of the
// same index (otherwise lookups are read-before-write).
module gshare_pht #(
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned HIST_WIDTH  = 10,
    parameter int unsigned CTR_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   lookup_valid,
    input  logic [INDEX_WIDTH-1:0] pc_fetch,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [HIST_WIDTH-1:0]  pred_hist,
    input  logic                   update_valid,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic [HIST_WIDTH-1:0]  update_hist,
    input  logic                   update_taken,
    input  logic                   update_mispredict
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic [HIST_WIDTH-1:0]  spec_hist_q, spec_hist_d;
    logic [CTR_WIDTH-1:0]   pht_q [DEPTH];

    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic [CTR_WIDTH-1:0]   wr_data;
    logic [INDEX_WIDTH-1:0] hist_ext;
    logic [CTR_WIDTH-1:0]   rd_ctr;
    logic [CTR_WIDTH-1:0]   upd_ctr;
    logic [CTR_WIDTH-1:0]   upd_next;
    logic                   taken_raw;

    assign ready     = (state_q == RUN);
    assign pred_hist = spec_hist_q;

    // Gshare index: history zero-extended into the low bits, XORed with the PC.
    always_comb begin
        hist_ext                 = '0;
        hist_ext[HIST_WIDTH-1:0] = spec_hist_q;
        pred_index               = pc_fetch ^ hist_ext;
    end

    // Saturating next value of the counter addressed by the resolving branch.
    always_comb begin
        upd_ctr  = pht_q[update_index];
        upd_next = upd_ctr;
        if (update_taken) begin
            if (upd_ctr != '1) upd_next = upd_ctr + CTR_WIDTH'(1);
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - CTR_WIDTH'(1);
        end
    end

    // Combinational prediction from the counter MSB, suppressed until ready.
    always_comb begin
        rd_ctr    = pht_q[pred_index];
        taken_raw = rd_ctr[CTR_WIDTH-1];
`ifdef PHT_FWD_EN
        if (update_valid && (update_index == pred_index)) taken_raw = upd_next[CTR_WIDTH-1];
`endif
        pred_taken = ready & taken_raw;
    end

    // Next-state: INIT sweeps the table; RUN handles history and counter updates.
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        spec_hist_d = spec_hist_q;
        wr_en       = 1'b0;
        wr_idx      = update_index;
        wr_data     = upd_next;
        case (state_q)
            INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_ptr_q;
                wr_data    = CTR_INIT;
                init_ptr_d = init_ptr_q + INDEX_WIDTH'(1);
                if (init_ptr_q == '1) state_d = RUN;
            end
            RUN: begin
                // Shift-then-OR keeps HIST_WIDTH=1 legal (shift empties the register).
                if (update_valid && update_mispredict) begin
                    spec_hist_d = (update_hist << 1) | HIST_WIDTH'(update_taken);
                end else if (lookup_valid) begin
                    spec_hist_d = (spec_hist_q << 1) | HIST_WIDTH'(pred_taken);
                end
                wr_en = update_valid;
            end
            default: state_d = INIT;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            spec_hist_q <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            spec_hist_q <= spec_hist_d;
        end
    end

    // Counter storage; cleared by the INIT sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_en) pht_q[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_gshare_pht.sv
// tb_gshare_pht: directed plus randomized checks of gshare_pht (4/4/2) against
// an arithmetic reference model, and a directed CTR_WIDTH=3 instance.
module tb_gshare_pht;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready, pred_taken;
    logic       lookup_valid, update_valid, update_taken, update_mispredict;
    logic [3:0] pc_fetch, pred_index, pred_hist, update_index, update_hist;

    logic       ready3, pred_taken3;
    logic [3:0] pred_index3, pred_hist3;
    logic       uv3, ut3;
    logic [3:0] pc3, ui3;

    int n_vec = 0;
    int n_mis = 0;

    // reference model state
    int  m_ctr [16];
    int  m_hist;
    bit  m_ready;
    int  m_cnt;

    logic       last_ready, last_pt;
    logic [3:0] last_idx, last_hist;

    always #5 clk = ~clk;

    gshare_pht #(.INDEX_WIDTH(4), .HIST_WIDTH(4), .CTR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .lookup_valid(lookup_valid), .pc_fetch(pc_fetch),
        .pred_taken(pred_taken), .pred_index(pred_index), .pred_hist(pred_hist),
        .update_valid(update_valid), .update_index(update_index),
        .update_hist(update_hist), .update_taken(update_taken),
        .update_mispredict(update_mispredict)
    );

    gshare_pht #(.INDEX_WIDTH(4), .HIST_WIDTH(4), .CTR_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .ready(ready3),
        .lookup_valid(1'b0), .pc_fetch(pc3),
        .pred_taken(pred_taken3), .pred_index(pred_index3), .pred_hist(pred_hist3),
        .update_valid(uv3), .update_index(ui3),
        .update_hist(4'h0), .update_taken(ut3),
        .update_mispredict(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    function automatic bit model_pred(input int idx, input bit uv, input int ui, input bit ut);
        int c;
        if (!m_ready) return 1'b0;
        c = m_ctr[idx];
`ifdef PHT_FWD_EN
        if (uv && ui == idx) c = sat(c, ut);
`endif
        return c >= 2;
    endfunction

    // Drive one cycle of inputs (in the low phase), check outputs, clock, advance model.
    task automatic step(input logic lv, input logic [3:0] pc, input logic uv,
                        input logic [3:0] ui, input logic [3:0] uh,
                        input logic ut, input logic um);
        int idx;
        bit ept;
        lookup_valid = lv; pc_fetch = pc; update_valid = uv; update_index = ui;
        update_hist = uh; update_taken = ut; update_mispredict = um;
        #1;
        idx = int'(pc) ^ m_hist;
        ept = model_pred(idx, uv, int'(ui), ut);
        chk("ready", ready, m_ready);
        chk("pred_index", pred_index, idx);
        chk("pred_hist", pred_hist, m_hist);
        chk("pred_taken", pred_taken, ept);
        last_ready = ready; last_pt = pred_taken; last_idx = pred_index; last_hist = pred_hist;
        @(posedge clk);
        if (m_ready) begin
            if (uv && um) m_hist = (int'(uh) * 2 + int'(ut)) % 16;
            else if (lv) m_hist = (m_hist * 2 + int'(ept)) % 16;
            if (uv) m_ctr[ui] = sat(m_ctr[ui], ut);
        end else begin
            m_cnt++;
            if (m_cnt == 16) begin
                m_ready = 1'b1;
                foreach (m_ctr[i]) m_ctr[i] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Idle step whose pc targets table entry idx under the current history.
    task automatic look(input int idx);
        step(1'b0, 4'(idx ^ m_hist), 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        lookup_valid = 0; update_valid = 0; update_mispredict = 0; uv3 = 0;
        rst = 1'b1;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_hist", pred_hist, 0);
        m_ready = 0; m_cnt = 0; m_hist = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_init();
        int n;
        n = 0;
        for (int g = 0; g < 40; g++) begin
            idle();
            if (last_ready === 1'b1) break;
            n++;
        end
        chk("init_cycles", n, 16);
    endtask

    initial begin
        rst = 1'b1;
        lookup_valid = 0; pc_fetch = 0; update_valid = 0; update_index = 0;
        update_hist = 0; update_taken = 0; update_mispredict = 0;
        uv3 = 0; ut3 = 0; pc3 = 4'h2; ui3 = 4'h2;
        @(negedge clk);

        // init length, then first lookup is not-taken with empty history
        do_reset();
        count_init();
        step(1'b1, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("init_pt", last_pt, 0);
        chk("init_hist", last_hist, 0);

        // reset reasserted mid-INIT restarts the full sweep
        do_reset();
        repeat (7) idle();
        do_reset();
        count_init();

        // saturation on entry 5
        repeat (3) step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0);
        look(5); chk("sat_up_pt", last_pt, 1);
        step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0);
        look(5); chk("sat_hi_hold", last_pt, 1);
        repeat (4) step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0);
        look(5); chk("sat_lo_hold", last_pt, 0);
        step(1'b0, 4'h0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0);
        look(5); chk("sat_lo_climb", last_pt, 1);

        // gshare index and history shift
        step(1'b0, 4'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("gs_idx0", last_idx, 4'h3);
        chk("gs_pt0", last_pt, 0);
        repeat (2) step(1'b0, 4'h0, 1'b1, 4'h3, 4'h0, 1'b1, 1'b0);
        step(1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("gs_pt1", last_pt, 1);
        step(1'b0, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("gs_idx1", last_idx, 4'h2);
        chk("gs_hist1", last_hist, 4'h1);

        // mispredict restore beats a same-cycle lookup shift
        step(1'b0, 4'h0, 1'b1, 4'hE, 4'h5, 1'b1, 1'b1);
        step(1'b1, 4'h6, 1'b1, 4'hE, 4'h4, 1'b1, 1'b1);
        chk("mp_hist_before", last_hist, 4'hB);
        idle();
        chk("mp_hist_after", last_hist, 4'h9);

        // same-cycle update and lookup of entry 7 (counter 01)
        step(1'b1, 4'(7 ^ m_hist), 1'b1, 4'h7, 4'h0, 1'b1, 1'b0);
`ifdef PHT_FWD_EN
        chk("coll_pt", last_pt, 1);
`else
        chk("coll_pt", last_pt, 0);
`endif
        look(7); chk("coll_after", last_pt, 1);
        step(1'b0, 4'h0, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0);
        look(7); chk("coll_once", last_pt, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), 4'($urandom), 1'($urandom_range(0, 9) < 4),
                 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // CTR_WIDTH=3 instance on entry 2 (no lookups, so index = pc)
        #1;
        chk("w3_ready", ready3, 1);
        chk("w3_init_pt", pred_taken3, 0);
        uv3 = 1; ut3 = 1;
        idle();
        uv3 = 0; #1;
        chk("w3_one_up", pred_taken3, 1);
        uv3 = 1;
        repeat (4) idle();
        ut3 = 0;
        repeat (3) idle();
        uv3 = 0; #1;
        chk("w3_sat_down3", pred_taken3, 1);
        uv3 = 1;
        idle();
        uv3 = 0; #1;
        chk("w3_sat_down4", pred_taken3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Next-generation pattern history table for the fetch-stage branch predictor.
- Generalises the single-index 2-bit table to N-bit saturating counters indexed gshare-style (PC bits XOR speculative global history).
- Adds speculative history update at fetch, snapshot-based recovery on mispredict, and a sequential post-reset table initialisation.
- Sits between fetch (lookup) and the branch-resolve stage (update).

Parameters:
- INDEX_WIDTH, 10, log2 of table depth; table holds 2**INDEX_WIDTH counters.
- HIST_WIDTH, 10, global history length. Legal range 1..INDEX_WIDTH.
- CTR_WIDTH, 2, saturating counter width. Legal range 2..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ready  out  1  table initialised; lookups and updates accepted only when 1.
- lookup_valid  in  1  fetch presents a branch lookup this cycle.
- pc_fetch  in  INDEX_WIDTH  pre-selected PC bits of the fetched branch.
- pred_taken  out  1  prediction; combinational from current state.
- pred_index  out  INDEX_WIDTH  table index used; carried down the pipeline.
- pred_hist  out  HIST_WIDTH  speculative history before this lookup's shift; carried down the pipeline.
- update_valid  in  1  resolved branch update.
- update_index  in  INDEX_WIDTH  pred_index carried with the branch.
- update_hist  in  HIST_WIDTH  pred_hist carried with the branch.
- update_taken  in  1  actual outcome.
- update_mispredict  in  1  predicted direction was wrong.

Behaviour:
- Index: pred_index = pc_fetch XOR zero-extended spec_hist, with history in the low bits.
- Counters:
  - Init value is 2**(CTR_WIDTH-1)-1, i.e. weakly not-taken (01 for CTR_WIDTH=2).
  - pred_taken = counter MSB, gated by ready.
  - Saturating arithmetic: taken increments unless the counter is all-ones; not-taken decrements unless it is zero. No wrap.
- FSM states: INIT, RUN.
  - rst asserted (asynchronously): state=INIT, init_ptr=0, spec_hist=0, ready=0, pred_taken=0.
  - INIT: write the init value to entry init_ptr each cycle and increment init_ptr.
  - INIT -> RUN on the cycle that writes entry 2**INDEX_WIDTH-1. INIT therefore lasts exactly 2**INDEX_WIDTH cycles after reset deasserts. ready=1 from the first RUN cycle.
  - INIT ignores lookup_valid and update_valid. Fetch must not issue while ready=0.
  - rst asserted mid-operation (including mid-INIT): returns to INIT with init_ptr=0; the whole table is rewritten.
- Speculative history, RUN only:
  - lookup_valid=1: spec_hist <= {spec_hist[HIST_WIDTH-2:0], pred_taken} at the next edge.
  - update_valid=1 and update_mispredict=1: spec_hist <= {update_hist[HIST_WIDTH-2:0], update_taken}.
  - Both in the same cycle: the mispredict restore wins and the lookup shift is discarded (wrong-path lookup).
  - HIST_WIDTH=1: the shift reduces to spec_hist <= new bit.
- Counter update, RUN only: update_valid=1 updates entry update_index at the next edge, regardless of update_mispredict.
- Same-cycle lookup and update to the same index: pred_taken reflects the pre-update counter (read-before-write), unless PHT_FWD_EN is defined.
- Lookup latency is 0 cycles (combinational read). Update becomes visible to lookups on the following cycle.

Optional Feature:
- Macro: PHT_FWD_EN.
- Defined: when update_valid=1 and update_index==pred_index in the same RUN cycle, pred_taken is the MSB of the post-update (saturated) counter value. This also changes the bit shifted into spec_hist.
- Not defined: pred_taken is read-before-write as above. No forwarding logic is synthesised.

Test Plan (INDEX_WIDTH=4, HIST_WIDTH=4, CTR_WIDTH=2 unless noted):
- Init: deassert rst -> ready=0 for exactly 16 cycles, then 1. Any lookup then gives pred_taken=0 and pred_hist=0000. Reassert rst at INIT cycle 7 -> ready stays 0 for 16 full cycles after release.
- Saturation: 3 taken updates to index 5 -> counter 11, lookup pred_taken=1. A 4th taken keeps 11. Then 4 not-taken -> 00, and a 5th keeps 00.
- Gshare index and history: spec_hist=0000, lookup pc_fetch=0011 -> pred_index=0011, pred_taken=0, spec_hist becomes 0000. Force counter[0011]=11 and relookup -> spec_hist becomes 0001. Next lookup pc_fetch=0011 -> pred_index=0010.
- Mispredict recovery: spec_hist=1011. Update with update_mispredict=1, update_hist=0100, update_taken=1, simultaneous with lookup_valid=1 -> spec_hist=1001 next cycle; the lookup shift is discarded.
- Same-index collision: counter[7]=01, update taken to 7 and lookup of index 7 in the same cycle -> pred_taken=0 without PHT_FWD_EN, 1 with it. Counter[7]=10 afterwards in both builds.
- Width generalisation (CTR_WIDTH=3): init value 011, pred_taken=0. One taken update -> 100, pred_taken=1. Saturates at 111.
